// File: rtl/macc_array.sv
`default_nettype none
// ============================================================================
//  Module      : macc_array
//  Description : On-chip N x N signed matrix multiply / multiply-accumulate.
//                Holds operands A, B and result C. One sequential MAC
//                computes C = A x B, or C += A x B, one product per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module macc_array #(
    parameter int N      = 4,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32,
    parameter int AW     = $clog2(N*N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [1:0]        wr_sel,
    input  logic [AW-1:0]     wr_addr,
    input  logic [ACC_W-1:0]  wr_data,
    input  logic              start,
    input  logic              acc_mode,
    input  logic              clear,
    output logic              busy,
    output logic              done,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [ACC_W-1:0]  rd_data,
    output logic              rd_valid
);

    localparam int c_idx_w = (N > 1) ? $clog2(N) : 1;
    localparam int c_ne    = N * N;
    localparam logic [c_idx_w-1:0] c_last = c_idx_w'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [c_idx_w-1:0]         i_q, i_d, j_q, j_d, k_q, k_d;
    logic [ACC_W-1:0]           acc_q, acc_d;
    logic                       mode_q, mode_d;
    logic [ACC_W-1:0]           rd_data_q;
    logic                       rd_valid_q;

    // Operand and result storage; deliberately left out of reset.
    logic [DATA_W-1:0]          a_mem_q [0:c_ne-1];
    logic [DATA_W-1:0]          b_mem_q [0:c_ne-1];
    logic [ACC_W-1:0]           c_mem_q [0:c_ne-1];

    logic [AW-1:0]              w_a_idx, w_b_idx, w_c_idx;
    logic signed [DATA_W-1:0]   w_a, w_b;
    logic signed [2*DATA_W-1:0] w_prod;
    logic [ACC_W-1:0]           w_sum, w_final;
    logic                       w_idle, w_host_wr, w_clear, w_mac_wr;

    assign w_idle    = (state_q == S_IDLE);
    assign w_host_wr = wr_en && w_idle;
    assign w_clear   = clear && w_idle;

    assign w_a_idx = AW'(int'(i_q) * N + int'(k_q));
    assign w_b_idx = AW'(int'(k_q) * N + int'(j_q));
    assign w_c_idx = AW'(int'(i_q) * N + int'(j_q));

    assign w_a    = a_mem_q[w_a_idx];
    assign w_b    = b_mem_q[w_b_idx];
    // Operands widened first so the product keeps its full signed range.
    assign w_prod = (2*DATA_W)'(w_a) * (2*DATA_W)'(w_b);
    // Sign-extended product; sums simply wrap at ACC_W bits.
    assign w_sum   = acc_q + ACC_W'(w_prod);
    assign w_final = w_sum + (mode_q ? c_mem_q[w_c_idx] : '0);

    // Control state, loop counters, accumulator and latched mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            mode_q  <= mode_d;
        end
    end

    // Next-state logic: k innermost, then j, then i; C written when k wraps.
    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        j_d      = j_q;
        k_d      = k_q;
        acc_d    = acc_q;
        mode_d   = mode_q;
        w_mac_wr = 1'b0;
        case (state_q)
            S_IDLE: begin
                // clear has priority over a coincident start
                if (start && !clear) begin
                    state_d = S_COMPUTE;
                    mode_d  = acc_mode;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    acc_d   = '0;
                end
            end
            S_COMPUTE: begin
                if (k_q == c_last) begin
                    w_mac_wr = 1'b1;
                    acc_d    = '0;
                    k_d      = '0;
                    if (j_q == c_last) begin
                        j_d = '0;
                        if (i_q == c_last) begin
                            i_d     = '0;
                            state_d = S_DONE;
                        end else begin
                            i_d = i_q + 1'b1;
                        end
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end else begin
                    acc_d = w_sum;
                    k_d   = k_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Host writes to the operand matrices, only while idle.
    always_ff @(posedge clk) begin
        if (w_host_wr && wr_sel == 2'd0) a_mem_q[wr_addr] <= wr_data[DATA_W-1:0];
        if (w_host_wr && wr_sel == 2'd1) b_mem_q[wr_addr] <= wr_data[DATA_W-1:0];
    end

    // Result matrix: bulk clear, MAC result write-back, or host preload.
    always_ff @(posedge clk) begin
        if (w_clear) begin
            for (int e = 0; e < c_ne; e++) c_mem_q[e] <= '0;
        end else if (w_mac_wr) begin
            c_mem_q[w_c_idx] <= w_final;
        end else if (w_host_wr && wr_sel == 2'd2) begin
            c_mem_q[wr_addr] <= wr_data;
        end
    end

    // Registered read port; reads only honoured while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            if (rd_en && w_idle) begin
                rd_data_q  <= c_mem_q[rd_addr];
                rd_valid_q <= 1'b1;
            end
        end
    end

    assign busy     = (state_q == S_COMPUTE);
    assign done     = (state_q == S_DONE);
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_macc_array.sv
`default_nettype none
// ============================================================================
//  Module      : tb_macc_array
//  Description : Directed self-checking bench for macc_array (N=2 and N=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_macc_array;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // N=2, DATA_W=8, ACC_W=16 instance
    logic        wr_en2, start2, acc_mode2, clear2, busy2, done2, rd_en2, rd_valid2;
    logic [1:0]  wr_sel2, wr_addr2, rd_addr2;
    logic [15:0] wr_data2, rd_data2;

    // default-parameter instance
    logic        wr_en4, start4, acc_mode4, clear4, busy4, done4, rd_en4, rd_valid4;
    logic [1:0]  wr_sel4;
    logic [3:0]  wr_addr4, rd_addr4;
    logic [31:0] wr_data4, rd_data4;

    int n_checks = 0;
    int n_errors = 0;

    macc_array #(.N(2), .DATA_W(8), .ACC_W(16)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en2), .wr_sel(wr_sel2),
        .wr_addr(wr_addr2), .wr_data(wr_data2), .start(start2),
        .acc_mode(acc_mode2), .clear(clear2), .busy(busy2), .done(done2),
        .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_data(rd_data2), .rd_valid(rd_valid2)
    );

    macc_array u_dut4 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en4), .wr_sel(wr_sel4),
        .wr_addr(wr_addr4), .wr_data(wr_data4), .start(start4),
        .acc_mode(acc_mode4), .clear(clear4), .busy(busy4), .done(done4),
        .rd_en(rd_en4), .rd_addr(rd_addr4), .rd_data(rd_data4), .rd_valid(rd_valid4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // All tasks begin and end just after a falling edge.
    task automatic w2(input logic [1:0] sel, input logic [1:0] addr, input int data);
        wr_en2 = 1'b1; wr_sel2 = sel; wr_addr2 = addr; wr_data2 = 16'(data);
        @(negedge clk);
        wr_en2 = 1'b0;
    endtask

    task automatic load2(input int a0, a1, a2, a3, b0, b1, b2, b3);
        w2(0, 0, a0); w2(0, 1, a1); w2(0, 2, a2); w2(0, 3, a3);
        w2(1, 0, b0); w2(1, 1, b1); w2(1, 2, b2); w2(1, 3, b3);
    endtask

    task automatic run2(input logic mode, input string tag);
        int cnt = 0;
        start2 = 1'b1; acc_mode2 = mode;
        @(negedge clk);
        start2 = 1'b0;
        while (busy2 && cnt < 100) begin cnt++; @(negedge clk); end
        check({tag, " busy cycles"}, cnt, 8);
        check({tag, " done"}, done2, 1);
        @(negedge clk);
        check({tag, " done one cycle"}, done2, 0);
    endtask

    task automatic rd2(input logic [1:0] addr, input logic [15:0] exp, input string tag);
        rd_en2 = 1'b1; rd_addr2 = addr;
        @(negedge clk);
        rd_en2 = 1'b0;
        check({tag, " valid"}, rd_valid2, 1);
        check(tag, rd_data2, exp);
    endtask

    task automatic readc2(input logic [15:0] c0, c1, c2, c3, input string tag);
        rd2(0, c0, {tag, " C00"}); rd2(1, c1, {tag, " C01"});
        rd2(2, c2, {tag, " C10"}); rd2(3, c3, {tag, " C11"});
    endtask

    task automatic w4(input logic [1:0] sel, input logic [3:0] addr, input int data);
        wr_en4 = 1'b1; wr_sel4 = sel; wr_addr4 = addr; wr_data4 = 32'(data);
        @(negedge clk);
        wr_en4 = 1'b0;
    endtask

    task automatic rd4(input logic [3:0] addr, input logic [31:0] exp, input string tag);
        rd_en4 = 1'b1; rd_addr4 = addr;
        @(negedge clk);
        rd_en4 = 1'b0;
        check({tag, " valid"}, rd_valid4, 1);
        check(tag, rd_data4, exp);
    endtask

    initial begin
        int cnt;
        int n_done;
        rst_n = 1'b0;
        {wr_en2, start2, acc_mode2, clear2, rd_en2} = '0;
        {wr_sel2, wr_addr2, rd_addr2, wr_data2} = '0;
        {wr_en4, start4, acc_mode4, clear4, rd_en4} = '0;
        {wr_sel4, wr_addr4, rd_addr4, wr_data4} = '0;
        repeat (2) @(negedge clk);
        check("reset busy", busy2, 0);
        check("reset done", done2, 0);
        check("reset rd_valid", rd_valid2, 0);
        check("reset rd_data", rd_data2, 0);
        check("reset rd_valid n4", rd_valid4, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic multiply, then accumulate, then clear
        load2(1, 2, 3, 4, 5, 6, 7, 8);
        run2(0, "mul");
        readc2(19, 22, 43, 50, "mul");
        @(negedge clk);
        check("rd_valid drops", rd_valid2, 0);
        run2(1, "acc");
        readc2(38, 44, 86, 100, "acc");
        clear2 = 1'b1; @(negedge clk); clear2 = 1'b0;
        readc2(0, 0, 0, 0, "clear");

        // Signed operands, then wraparound
        load2(-1, 0, 0, -1, 3, -4, 5, 6);
        run2(0, "signed");
        readc2(-3, 4, -5, -6, "signed");
        load2(-128, -128, -128, -128, -128, -128, -128, -128);
        run2(0, "wrap");
        readc2(16'h8000, 16'h8000, 16'h8000, 16'h8000, "wrap");

        // Writes, start and reads while busy are ignored
        load2(1, 2, 3, 4, 5, 6, 7, 8);
        start2 = 1'b1; acc_mode2 = 1'b0;
        @(negedge clk);
        wr_en2 = 1'b1; wr_sel2 = 2'd0; wr_addr2 = 2'd0; wr_data2 = 16'd9;
        rd_en2 = 1'b1; rd_addr2 = 2'd0;
        repeat (3) begin
            @(negedge clk);
            check("busy rd_valid", rd_valid2, 0);
            check("busy rd_data hold", rd_data2, 16'h8000);
        end
        wr_en2 = 1'b0; rd_en2 = 1'b0; start2 = 1'b0;
        cnt = 0;
        while (!done2 && cnt < 100) begin cnt++; @(negedge clk); end
        check("busy run done", done2, 1);
        @(negedge clk);
        n_done = 0;
        repeat (20) begin
            if (done2 || busy2) n_done++;
            @(negedge clk);
        end
        check("no second run", n_done, 0);
        readc2(19, 22, 43, 50, "busy write ignored");

        // Asynchronous reset during compute, then a clean rerun
        clear2 = 1'b1; @(negedge clk); clear2 = 1'b0;
        start2 = 1'b1; acc_mode2 = 1'b0;
        @(negedge clk);
        start2 = 1'b0;
        repeat (3) @(negedge clk);
        check("mid busy", busy2, 1);
        rst_n = 1'b0;
        #1;
        check("abort busy", busy2, 0);
        check("abort done", done2, 0);
        check("abort rd_valid", rd_valid2, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run2(0, "rerun");
        readc2(19, 22, 43, 50, "rerun");

        // Default parameters: identity times 0..15
        for (int e = 0; e < 16; e++) begin
            w4(0, 4'(e), (e / 4 == e % 4) ? 1 : 0);
            w4(1, 4'(e), e);
        end
        start4 = 1'b1; acc_mode4 = 1'b0;
        @(negedge clk);
        start4 = 1'b0;
        cnt = 0;
        while (busy4 && cnt < 200) begin cnt++; @(negedge clk); end
        check("n4 busy cycles", cnt, 64);
        check("n4 done", done4, 1);
        @(negedge clk);
        rd4(15, 15, "n4 C15");
        rd4(6, 6, "n4 C6");
        rd4(0, 0, "n4 C0");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/macc_array.md
Name: macc_array

Overview:
- Parametrised successor to the pass-through matrix block: holds operand matrices A and B plus result matrix C on-chip.
- Computes C = A×B, or C += A×B in accumulate mode, using one sequential signed multiply-accumulate unit.
- Host logic, such as the PS-side AXI glue, loads operands through a word write port, pulses start and waits for done.
- Results are read back through a registered read port.

Parameters:
- N, 4: matrix dimension (N×N); legal range 2..16.
- DATA_W, 16: signed operand width (A, B elements).
- ACC_W, 32: signed accumulator/result width (C elements); must satisfy ACC_W >= 2*DATA_W.
- AW, $clog2(N*N): element address width, derived; addr = row*N + col (row-major).

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  operand/result write strobe.
- wr_sel  in  2  target: 0=A, 1=B, 2=C (preload C for accumulate), 3=reserved (write ignored).
- wr_addr  in  AW  element address.
- wr_data  in  ACC_W  write data; the low DATA_W bits are used for A/B, the full width for C.
- start  in  1  one-cycle start pulse.
- acc_mode  in  1  sampled with start: 0 → C = A×B; 1 → C = C + A×B.
- clear  in  1  one-cycle pulse; zeroes all C entries.
- busy  out  1  computation in progress.
- done  out  1  one-cycle completion pulse.
- rd_en  in  1  result read strobe.
- rd_addr  in  AW  C element address.
- rd_data  out  ACC_W  C element, registered.
- rd_valid  out  1  qualifies rd_data.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - busy=0, done=0, rd_valid=0, rd_data=0.
  - Internal i/j/k counters and the accumulator are zeroed.
  - A, B and C contents are not cleared.
  - Reset mid-COMPUTE aborts the operation; partially written C is undefined until reloaded or cleared.
- FSM states:
  - IDLE: start → COMPUTE. On that edge, latch acc_mode and set i=j=k=0. busy rises the next cycle.
  - COMPUTE: one MAC per cycle, acc += A[i][k]*B[k][j], with k innermost, then j, then i.
    - At k=N-1, write C[i][j] = acc_final. acc_final is the running sum plus the initial C[i][j] when acc_mode=1.
    - Then reset acc and advance j/i.
    - After the last element (i=j=k=N-1) → DONE.
  - DONE: busy=0, done=1 for exactly one cycle, then → IDLE.
- Latency: start sampled at edge T0 → busy high for exactly N³ cycles (T1..T(N³)) → done high at T(N³+1).
- Arithmetic:
  - Operands are signed DATA_W; products are 2*DATA_W signed, sign-extended to ACC_W.
  - Sums wrap modulo 2^ACC_W with no saturation and no overflow flag.
- Writes:
  - Take effect on the edge with wr_en=1.
  - Ignored while busy=1 or in DONE.
  - wr_sel=3 is ignored.
- clear: zeroes C in one cycle when IDLE; ignored while busy.
- start rules:
  - Ignored while busy or in DONE.
  - If start and wr_en coincide in IDLE, the write commits first and the computation sees the new value.
  - If start and clear coincide, clear wins and start is ignored.
- Reads:
  - rd_en in IDLE → rd_data=C[rd_addr] and rd_valid=1 on the next cycle.
  - rd_valid=0 in any cycle following no rd_en.
  - rd_en while busy is ignored: rd_valid=0 and rd_data holds its previous value.
  - A read and a C write to the same address in the same cycle return the old value.
- Back-to-back: start asserted in the same cycle as done is ignored; the earliest accepted restart is the cycle after done.

Test Plan:
- N=2, DATA_W=8, ACC_W=16; load A=[[1,2],[3,4]], B=[[5,6],[7,8]], start with acc_mode=0 → busy for 8 cycles, done at T9; read C=[[19,22],[43,50]].
- Same setup, then start again with acc_mode=1 → C=[[38,44],[86,100]]; then clear and read → all 0.
- Signed and wrap check: A=[[-1,0],[0,-1]], B=[[3,-4],[5,6]] → C=[[-3,4],[-5,-6]]. Then A and B all -128 → every C = 0x8000 (32768 wraps to -32768).
- Write A[0][0]=9 while busy, and assert start and rd_en while busy → the A write is not applied, no second done, rd_valid stays 0. The next run uses the original A.
- Deassert rst_n midway through COMPUTE (cycle 4 of 8) → busy, done and rd_valid are 0 immediately. After release, start the run again → completes normally with correct C.
- N=4 defaults: A=identity, B = element values 0..15 (row-major) → C=B. done at exactly T65; a read at address 15 returns 15 with rd_valid one cycle after rd_en.
